// File: rtl/memory_reader_ctrl_if.sv
// Handshake and datapath-control bundle between the memory reader sequencer
// and its datapath / convolution controller.
interface memory_reader_ctrl_if;
  logic       start;
  logic       img_base_sel;
  logic       busy;
  logic       done;
  logic       adr_sel;
  logic [1:0] mem_offset_sel;
  logic       img_wr_en;
  logic       filter_wr_en;
  logic [7:0] countr_img;
  logic [7:0] countr_filters;
  logic [7:0] countr4_filter;

  modport master (
    input  start, img_base_sel,
    output busy, done, adr_sel, mem_offset_sel, img_wr_en, filter_wr_en,
           countr_img, countr_filters, countr4_filter
  );

  modport slave (
    output start, img_base_sel,
    input  busy, done, adr_sel, mem_offset_sel, img_wr_en, filter_wr_en,
           countr_img, countr_filters, countr4_filter
  );
endinterface

// File: rtl/memory_reader_ctrl.sv
// Sequencer copying one image then NUM_FILTERS 4-word filters out of word memory.
// Define MEM_RD_WAIT_EN for a registered-read memory (2 cycles per word).
module memory_reader_ctrl #(
  parameter int unsigned IMG_SIZE    = 16,
  parameter int unsigned NUM_FILTERS = 4
) (
  input logic                  clk,
  input logic                  rst,
  memory_reader_ctrl_if.master bus
);

  localparam int unsigned ImgWords = IMG_SIZE * IMG_SIZE / 4;
  localparam logic [7:0]  ImgLast  = 8'(ImgWords - 1);
  localparam logic [7:0]  FltLast  = 8'(NUM_FILTERS - 1);

  typedef enum logic [1:0] {StIdle, StLdImg, StLdFlt, StDone} state_e;

  state_e     state_q, state_d;
  logic       base_sel_q, base_sel_d;
  logic [7:0] cnt_img_q, cnt_img_d;
  logic [7:0] cnt_flt_q, cnt_flt_d;
  logic [7:0] cnt4_q, cnt4_d;
  logic       step;  // current word is written this cycle

`ifdef MEM_RD_WAIT_EN
  logic phase_q, phase_d;

  // Address phase (0) then write phase (1) for every word.
  always_comb begin
    phase_d = 1'b0;
    if (state_q == StLdImg || state_q == StLdFlt) phase_d = ~phase_q;
  end

  always_ff @(posedge clk) begin
    if (rst) phase_q <= 1'b0;
    else     phase_q <= phase_d;
  end

  assign step = phase_q;
`else
  assign step = 1'b1;
`endif

  always_comb begin
    state_d    = state_q;
    base_sel_d = base_sel_q;
    cnt_img_d  = cnt_img_q;
    cnt_flt_d  = cnt_flt_q;
    cnt4_d     = cnt4_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          base_sel_d = bus.img_base_sel;
          cnt_img_d  = 8'd0;
          cnt_flt_d  = 8'd0;
          cnt4_d     = 8'd0;
          state_d    = StLdImg;
        end
      end
      StLdImg: begin
        if (step) begin
          if (cnt_img_q == ImgLast) begin
            cnt_img_d = 8'd0;
            state_d   = StLdFlt;
          end else begin
            cnt_img_d = cnt_img_q + 8'd1;
          end
        end
      end
      StLdFlt: begin
        if (step) begin
          if (cnt4_q == 8'd3) begin
            cnt4_d = 8'd0;
            if (cnt_flt_q == FltLast) begin
              cnt_flt_d = 8'd0;
              state_d   = StDone;
            end else begin
              cnt_flt_d = cnt_flt_q + 8'd1;
            end
          end else begin
            cnt4_d = cnt4_q + 8'd1;
          end
        end
      end
      StDone: begin
        cnt_img_d = 8'd0;
        cnt_flt_d = 8'd0;
        cnt4_d    = 8'd0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      base_sel_q <= 1'b0;
      cnt_img_q  <= 8'd0;
      cnt_flt_q  <= 8'd0;
      cnt4_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      base_sel_q <= base_sel_d;
      cnt_img_q  <= cnt_img_d;
      cnt_flt_q  <= cnt_flt_d;
      cnt4_q     <= cnt4_d;
    end
  end

  // Decodes of registered state only; enables line up with the counter they write.
  always_comb begin
    bus.busy           = (state_q != StIdle);
    bus.done           = (state_q == StDone);
    bus.adr_sel        = (state_q == StLdImg);
    bus.mem_offset_sel = 2'd0;
    if (state_q == StLdImg)      bus.mem_offset_sel = base_sel_q ? 2'd2 : 2'd0;
    else if (state_q == StLdFlt) bus.mem_offset_sel = 2'd1;
    bus.img_wr_en      = (state_q == StLdImg) && step;
    bus.filter_wr_en   = (state_q == StLdFlt) && step;
    bus.countr_img     = cnt_img_q;
    bus.countr_filters = cnt_flt_q;
    bus.countr4_filter = cnt4_q;
  end

endmodule
